// File: rtl/adder_pkg.sv
// adder_pkg: kill/propagate/generate encoding and prefix combine shared by adder blocks
package adder_pkg;
    typedef enum logic [1:0] {KILL = 2'b00, PROP = 2'b01, GEN = 2'b11} kpg_t;

    function automatic kpg_t kpg_encode(input logic x, input logic y);
        return (x & y) ? GEN : (x ^ y) ? PROP : KILL;
    endfunction

    function automatic kpg_t kpg_combine(input kpg_t hi, input kpg_t lo);
        return (hi == PROP) ? lo : hi;
    endfunction
endpackage

// File: rtl/kpg_cell.sv
// kpg_cell: one Kogge-Stone prefix node combining a higher and a lower kpg group
module kpg_cell import adder_pkg::*; (
    input  kpg_t hi,
    input  kpg_t lo,
    output kpg_t y
);
    assign y = kpg_combine(hi, lo);
endmodule

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: Kogge-Stone add/sub with configurable register ranks and global stall
module pipelined_prefix_adder import adder_pkg::*; #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    parameter int SB_W   = 74
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [SB_W-1:0]  sb_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [SB_W-1:0]  sb_out
);
    localparam int L = $clog2(WIDTH);

    function automatic bit has_rank(input int lvl);
        bit r = 1'b0;
        for (int k = 1; k < STAGES; k++) r |= ((k * L + STAGES - 1) / STAGES == lvl);
        return r;
    endfunction

    logic             advance;
    logic [WIDTH-1:0] bx;
    logic             c0;
    logic [WIDTH:0]   carry;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;
    assign bx       = sub ? ~b : b;
    assign c0       = sub | cin;

    for (genvar l = 0; l <= L; l++) begin : lv
        logic [WIDTH-1:0][1:0] pd, pq;
        logic [WIDTH-1:0]      xd, xq;
        logic [SB_W-1:0]       sd, sq;
        logic                  cd, cq, vd, vq;
        if (l == 0) begin : enc
            // carry-in acts as a virtual position below bit 0, so no group ever stays PROP
            always_comb begin
                for (int i = 0; i < WIDTH; i++) pd[i] = kpg_encode(a[i], bx[i]);
                pd[0] = kpg_combine(kpg_encode(a[0], bx[0]), c0 ? GEN : KILL);
            end
            assign xd = a ^ bx;
            assign cd = c0;
            assign sd = sb_in;
            assign vd = in_valid;
        end else begin : pfx
            for (genvar i = 0; i < WIDTH; i++) begin : n
                if (i >= (1 << (l - 1))) begin : c
                    kpg_cell u_cell (
                        .hi(kpg_t'(lv[l-1].pq[i])),
                        .lo(kpg_t'(lv[l-1].pq[i-(1<<(l-1))])),
                        .y (pd[i])
                    );
                end else begin : p
                    assign pd[i] = lv[l-1].pq[i];
                end
            end
            assign xd = lv[l-1].xq;
            assign cd = lv[l-1].cq;
            assign sd = lv[l-1].sq;
            assign vd = lv[l-1].vq;
        end
        if (has_rank(l)) begin : rk
            always_ff @(posedge clk or negedge rst)
                if (!rst) {pq, xq, cq, sq, vq} <= '0;
                else if (advance) {pq, xq, cq, sq, vq} <= {pd, xd, cd, sd, vd};
        end else begin : wr
            assign {pq, xq, cq, sq, vq} = {pd, xd, cd, sd, vd};
        end
    end

    always_comb begin
        carry[0] = lv[L].cq;
        for (int i = 0; i < WIDTH; i++) carry[i+1] = (lv[L].pq[i] == GEN);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) {sum, cout, ovf, sb_out, out_valid} <= '0;
        else if (advance) begin
            sum       <= lv[L].xq ^ carry[WIDTH-1:0];
            cout      <= carry[WIDTH];
            ovf       <= carry[WIDTH] ^ carry[WIDTH-1];
            sb_out    <= lv[L].sq;
            out_valid <= lv[L].vq;
        end
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb_pipelined_prefix_adder: directed checks on the 64-bit adder plus an 8-bit sweep at STAGES 1 and 4
module tb_pipelined_prefix_adder;
    logic        clk, rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] a, b, sum;
    logic        cin, sub, cout, ovf;
    logic [73:0] sb_in, sb_out;

    logic [7:0]  a8, b8, s1_sum, s4_sum;
    logic        cin8, sub8, v8;
    logic [15:0] sb8, s1_sb, s4_sb;
    logic        s1_rdy, s1_ov, s1_co, s1_of, s4_rdy, s4_ov, s4_co, s4_of;

    int n_checks = 0;
    int n_fail   = 0;

    pipelined_prefix_adder u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .sb_in(sb_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .sb_out(sb_out)
    );

    pipelined_prefix_adder #(.WIDTH(8), .STAGES(1), .SB_W(16)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(s1_rdy), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .sb_in(sb8), .out_valid(s1_ov), .out_ready(1'b1),
        .sum(s1_sum), .cout(s1_co), .ovf(s1_of), .sb_out(s1_sb)
    );

    pipelined_prefix_adder #(.WIDTH(8), .STAGES(4), .SB_W(16)) u_s4 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(s4_rdy), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .sb_in(sb8), .out_valid(s4_ov), .out_ready(1'b1),
        .sum(s4_sum), .cout(s4_co), .ovf(s4_of), .sb_out(s4_sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // reference built on plain integer addition, result packed as {cout, ovf, sum}
    function automatic logic [9:0] m8(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic sb);
        logic [7:0] yb;
        logic [8:0] s;
        logic       o;
        yb = sb ? ~y : y;
        s  = {1'b0, x} + {1'b0, yb} + {8'd0, sb | ci};
        o  = (x[7] == yb[7]) && (s[7] != x[7]);
        return {s[8], o, s[7:0]};
    endfunction

    logic [7:0] bset [16] = '{8'h00, 8'h01, 8'h02, 8'h7f, 8'h80, 8'h81, 8'hfe, 8'hff,
                              8'h55, 8'haa, 8'h0f, 8'hf0, 8'h33, 8'h3c, 8'h40, 8'hc1};

    function automatic logic [9:0] vec_exp(input int j);
        logic [1:0] md;
        md = 2'(j / 4096);
        return m8(8'(j), bset[(j / 256) % 16], md == 2'd1, md == 2'd2);
    endfunction

    task automatic run_one(input string tag, input logic [63:0] ta, input logic [63:0] tb_,
                           input logic tcin, input logic tsub, input logic [73:0] tsb,
                           input logic [63:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        a = ta; b = tb_; cin = tcin; sub = tsub; sb_in = tsb; in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, "_rdy"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0; a = ~ta; b = ~tb_; sub = ~tsub; sb_in = ~tsb;
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (out_valid) lat = k;
        end
        check({tag, "_lat"}, lat, 2);
        check({tag, "_sum"}, sum, es);
        check({tag, "_co_ov"}, {cout, ovf}, {ec, eo});
        check({tag, "_sb"}, sb_out, tsb);
    endtask

    initial begin
        int idx, got, stalls, stale;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sb_in = '0;
        v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; sb8 = '0;
        #2;
        check("rst_out", {out_valid, cout, ovf, sum, sb_out}, 0);
        check("rst_rdy", in_ready, 1);
        check("rst_out8", {s1_ov, s4_ov, s1_sum, s4_sum, s1_sb, s4_sb}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_one("ones_p1",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 74'd1, 64'd0, 1'b1, 1'b0);
        run_one("5m7",      64'd5, 64'd7, 1'b0, 1'b1, 74'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_one("7m5",      64'd7, 64'd5, 1'b0, 1'b1, 74'd3, 64'd2, 1'b1, 1'b0);
        run_one("maxp1",    64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 74'd4, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_one("minm1",    64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 74'd5, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        run_one("cin_wrap", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0,
                74'h2_0000_0000_0000_0000, 64'd0, 1'b1, 1'b0);
        run_one("sub_cin",  64'd10, 64'd3, 1'b1, 1'b1, 74'd7, 64'd7, 1'b1, 1'b0);
        run_one("min_min",  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 74'd8, 64'd0, 1'b1, 1'b1);

        // four ops while the consumer refuses output for three cycles
        @(negedge clk);
        out_ready = 1'b0; idx = 0; got = 0; stalls = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (out_valid && !out_ready) begin
                #1;
                check("stall_rdy", in_ready, 0);
                check("stall_sb", sb_out, 1);
                check("stall_sum", sum, 101);
                stalls++;
                if (stalls == 3) out_ready = 1'b1;
            end
            in_valid = idx < 4; a = 64'((idx + 1) * 100); b = 64'(idx + 1); cin = 1'b0; sub = 1'b0;
            sb_in = 74'(idx + 1);
            #1;
            if (out_valid && out_ready) begin
                check("stall_ord", sb_out, 128'(got + 1));
                check("stall_res", sum, 128'(101 * (got + 1)));
                got++;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        check("stall_cnt", got, 4);
        check("stall_cyc", stalls, 3);

        // reset with two operations in flight
        @(negedge clk);
        a = 64'd1; b = 64'd2; sub = 1'b0; cin = 1'b0; sb_in = 74'hA1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 sb_in = 74'hA2;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("prerst_ov", out_valid, 1);
        rst = 1'b0;
        #1;
        check("rst_flush", {out_valid, cout, ovf, sum, sb_out}, 0);
        check("rst_rdy2", in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("stale", stale, 0);
        run_one("post_rst", 64'd40, 64'd2, 1'b0, 1'b0, 74'h5A, 64'd42, 1'b0, 1'b0);

        // 8-bit streaming sweep: output of vector c-S must appear at sample c
        for (int c = 0; c < 12288 + 4; c++) begin
            @(negedge clk);
            if (c >= 1 && c - 1 < 12288)
                check("s1_res", {s1_ov, s1_sb, s1_co, s1_of, s1_sum}, {1'b1, 16'(c - 1), vec_exp(c - 1)});
            else
                check("s1_idle", s1_ov, 0);
            if (c >= 4 && c - 4 < 12288)
                check("s4_res", {s4_ov, s4_sb, s4_co, s4_of, s4_sum}, {1'b1, 16'(c - 4), vec_exp(c - 4)});
            else
                check("s4_idle", s4_ov, 0);
            v8 = c < 12288;
            a8 = 8'(c);
            b8 = bset[(c / 256) % 16];
            cin8 = (c / 4096) == 1;
            sub8 = (c / 4096) == 2;
            sb8 = 16'(c);
        end
        v8 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_prefix_adder.md
PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

Interface
REQ-001 SHALL have parameter WIDTH, 64, operand width; legal values are powers of two from 8 to 128.
REQ-002 SHALL have parameter STAGES, 2, number of register ranks from input to output, inclusive; legal range 1..clog2(WIDTH)+1.
REQ-003 SHALL have parameter SB_W, 74, width of the sideband pass-through bus.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  operands present.
REQ-007 SHALL have port in_ready  output  1  operands accepted this cycle if in_valid.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port cin  input  1  carry-in; ignored when sub=1.
REQ-011 SHALL have port sub  input  1  mode: 0 is A+B+cin, 1 is A-B.
REQ-012 SHALL have port sb_in  input  SB_W  sideband, travels with operands.
REQ-013 SHALL have port out_valid  output  1  result present.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result.
REQ-015 SHALL have port sum  output  WIDTH  result.
REQ-016 SHALL have port cout  output  1  carry out of MSB; for sub, 1 means no borrow.
REQ-017 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-018 SHALL have port sb_out  output  SB_W  sideband aligned with sum.

Function
REQ-019 SHALL form effective operands: B' = sub ? ~b : b, and c0 = sub ? 1 : cin.
REQ-020 SHALL encode each bit position as kill/propagate/generate from (a[i], B'[i]); position 0 SHALL fold in c0.
REQ-021 SHALL resolve carries with a Kogge-Stone prefix network of L = clog2(WIDTH) levels of kpg combine.
REQ-022 SHALL produce sum[i] = a[i]^B'[i]^carry[i], cout = carry[WIDTH], and ovf = carry[WIDTH]^carry[WIDTH-1].
REQ-023 SHALL place register rank k (1..STAGES-1) after prefix level ceil(k*L/STAGES); rank STAGES SHALL be the output register driving sum/cout/ovf/sb_out/out_valid.
REQ-024 SHALL make latency exactly STAGES cycles from acceptance to out_valid when out_ready is held at 1.
REQ-025 SHALL give every rank a valid bit; sideband and the a^B' bits SHALL ride in the same ranks as the prefix data.
REQ-026 SHALL define advance = out_ready | ~out_valid, and drive in_ready = advance; all ranks SHALL shift only when advance=1.
REQ-027 SHALL keep every rank, including the output, unchanged while advance=0 (global stall): no loss, no duplication, order preserved.
REQ-028 SHALL, on acceptance, compute a new result even when ranks hold bubbles; bubbles SHALL NOT collapse; throughput SHALL be one result per cycle when unstalled.
REQ-029 SHALL hold sum/cout/ovf/sb_out stable while out_valid=1 and out_ready=0.
REQ-030 SHALL ignore a, b, cin, sub and sb_in when in_valid=0 or in_ready=0.

Reset
REQ-031 SHALL, while rst=0, clear all valid bits, out_valid, sum, cout, ovf and sb_out to 0 asynchronously; in_ready SHALL read 1.
REQ-032 SHALL discard in-flight operations on reset mid-operation; the first result after release SHALL come from the first operand accepted after release.
REQ-033 SHALL resume accepting on the first rising clk edge with rst=1.

Structure
REQ-034 SHALL take the 2-bit kpg encoding (KILL=00, PROP=01, GEN=11) and the kpg combine function from shared package adder_pkg.
REQ-035 SHALL implement the prefix combine as sub-module kpg_cell (inputs: higher and lower kpg; output: combined kpg), instantiated per node.
REQ-036 SHALL contain no latches and no combinational path from a, b, cin or sub to any output.

Verification
REQ-037 SHALL cover: WIDTH=64, STAGES=2, a=all-ones, b=1, sub=0, cin=0 -> sum=0, cout=1, ovf=0, out_valid exactly 2 cycles after acceptance.
REQ-038 SHALL cover: a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-039 SHALL cover: a=0x7FFF_FFFF_FFFF_FFFF, b=1, add -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
REQ-040 SHALL cover: 4 back-to-back operations with sb_in=1..4 and out_ready=0 for 3 cycles -> in_ready=0 during the stall, outputs held, then results for sb_out 1,2,3,4 in order with none lost.
REQ-041 SHALL cover: rst pulsed low with 2 operations in flight -> out_valid=0 immediately; no stale result emerges after release.
REQ-042 SHALL cover: WIDTH=8 with STAGES=1 and STAGES=4, exhaustive a, b, sub, cin -> matches the reference model, with latency equal to STAGES.
